// File: rtl/ps2_keymap_decoder_pkg.sv
// Shared definitions for the PS/2 Set-2 keymap decoder: FSM states, protocol
// bytes and the game's default key table.
package ps2_keymap_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_e;

  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Bytes that follow E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  // {ext, byte} codes; bit 8 set means the E0 prefix is required.
  localparam logic [8:0] KC_W     = 9'h01D;
  localparam logic [8:0] KC_A     = 9'h01C;
  localparam logic [8:0] KC_S     = 9'h01B;
  localparam logic [8:0] KC_D     = 9'h023;
  localparam logic [8:0] KC_I     = 9'h043;
  localparam logic [8:0] KC_J     = 9'h03B;
  localparam logic [8:0] KC_K     = 9'h042;
  localparam logic [8:0] KC_L     = 9'h04B;
  localparam logic [8:0] KC_SPACE = 9'h029;
  localparam logic [8:0] KC_ENTER = 9'h05A;
  localparam logic [8:0] KC_ESC   = 9'h076;
  localparam logic [8:0] KC_UP    = 9'h175;
  localparam logic [8:0] KC_DOWN  = 9'h172;
  localparam logic [8:0] KC_LEFT  = 9'h16B;
  localparam logic [8:0] KC_RIGHT = 9'h174;

  localparam int unsigned DEFAULT_NUM_KEYS = 11;

  // Entry 0 in the low bits: W A S D UP DOWN LEFT RIGHT SPACE ENTER ESC.
  localparam logic [DEFAULT_NUM_KEYS*9-1:0] DEFAULT_KEY_CODES = {
    KC_ESC, KC_ENTER, KC_SPACE, KC_RIGHT, KC_LEFT, KC_DOWN,
    KC_UP, KC_D, KC_S, KC_A, KC_W
  };

  function automatic logic is_abort_byte(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_FF) || (b == BYTE_AA);
  endfunction

endpackage

// File: rtl/ps2_keymap_decoder_code_match.sv
// Combinational lookup of one {ext, byte} code against the key table; every
// matching entry raises its hit bit, so duplicate entries track together.
module ps2_keymap_decoder_code_match #(
  parameter int unsigned           NUM_KEYS  = 11,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = '0
) (
  input  logic [8:0]          code_i,
  output logic [NUM_KEYS-1:0] hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit_o[i] = (KEY_CODES[9*i +: 9] == code_i);
    end
  end

endmodule

// File: rtl/ps2_keymap_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, stall timeout, Pause skipping and
// registered held/press/release vectors for a table of mapped keys.
module ps2_keymap_decoder
  import ps2_keymap_decoder_pkg::*;
#(
  parameter int unsigned           NUM_KEYS       = DEFAULT_NUM_KEYS,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = DEFAULT_KEY_CODES,
  parameter logic [31:0]           TIMEOUT_CYCLES = 32'd5_000_000,
  parameter int unsigned           CNT_W          = 23
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          data,
  input  logic                data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic [8:0]          last_code,
  output logic                last_valid,
  output logic                proto_err
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [2:0]          skip_q, skip_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [8:0]          last_code_q, last_code_d;
  logic                last_valid_q, last_valid_d;
  logic                proto_err_q, proto_err_d;

  logic                ext_s;
  logic [8:0]          match_code_s;
  logic [NUM_KEYS-1:0] hit_s;
  logic                waiting_s;
  logic                do_make_s;
  logic                do_break_s;

  assign ext_s        = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign match_code_s = {ext_s, data};
  assign waiting_s    = (state_q != ST_IDLE);

  ps2_keymap_decoder_code_match #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_CODES (KEY_CODES)
  ) u_code_match (
    .code_i (match_code_s),
    .hit_o  (hit_s)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    skip_d       = skip_q;
    held_d       = held_q;
    press_d      = '0;
    release_d    = '0;
    last_code_d  = last_code_q;
    last_valid_d = 1'b0;
    proto_err_d  = 1'b0;
    do_make_s    = 1'b0;
    do_break_s   = 1'b0;

    if (data_en) begin
      timer_d = '0;
      if (state_q == ST_SKIP) begin
        if (skip_q <= 3'd1) begin
          skip_d  = 3'd0;
          state_d = ST_IDLE;
        end else begin
          skip_d = skip_q - 3'd1;
        end
      end else if (is_abort_byte(data)) begin
        // Keyboard reset/overrun: drop every held key silently.
        held_d      = '0;
        proto_err_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (data == BYTE_F0) begin
              state_d = ST_BRK;
            end else if (data == BYTE_E0) begin
              state_d = ST_EXT;
            end else if (data == BYTE_E1) begin
              state_d = ST_SKIP;
              skip_d  = PAUSE_SKIP_LEN;
            end else begin
              do_make_s = 1'b1;
            end
          end
          ST_EXT: begin
            if (data == BYTE_F0) begin
              state_d = ST_EXT_BRK;
            end else if (data == BYTE_E0) begin
              state_d = ST_EXT;
            end else begin
              do_make_s = 1'b1;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            if (data == BYTE_E0) begin
              proto_err_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              do_break_s = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (waiting_s) begin
      if (timer_q >= TMO_LAST) begin
        timer_d     = '0;
        state_d     = ST_IDLE;
        proto_err_d = 1'b1;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end else begin
      timer_d = '0;
    end

    if (do_make_s) begin
      press_d      = hit_s & ~held_q;
      held_d       = held_q | hit_s;
      last_code_d  = match_code_s;
      last_valid_d = 1'b1;
      state_d      = ST_IDLE;
    end else if (do_break_s) begin
      release_d    = hit_s & held_q;
      held_d       = held_q & ~hit_s;
      last_code_d  = match_code_s;
      last_valid_d = 1'b1;
      state_d      = ST_IDLE;
    end else begin
      last_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      skip_q       <= 3'd0;
      held_q       <= '0;
      press_q      <= '0;
      release_q    <= '0;
      last_code_q  <= 9'd0;
      last_valid_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      skip_q       <= skip_d;
      held_q       <= held_d;
      press_q      <= press_d;
      release_q    <= release_d;
      last_code_q  <= last_code_d;
      last_valid_q <= last_valid_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_held    = |held_q;
  assign last_code   = last_code_q;
  assign last_valid  = last_valid_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Bench for ps2_keymap_decoder: directed vector table, random byte stream
// against a prefix-list reference model, plus timeout and reset sequences.
module tb_ps2_keymap_decoder;

  localparam int NK  = 11;
  localparam int TMO = 40;

  localparam logic [8:0] TB_CODES [NK] = '{
    9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175, 9'h172,
    9'h16B, 9'h174, 9'h029, 9'h05A, 9'h076
  };

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          data_en = 1'b0;
  logic [NK-1:0] key_held, key_press, key_release;
  logic          any_held;
  logic [8:0]    last_code;
  logic          last_valid, proto_err;

  int checks = 0;
  int errors = 0;

  ps2_keymap_decoder #(
    .NUM_KEYS       (NK),
    .TIMEOUT_CYCLES (32'd40),
    .CNT_W          (6)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .data        (data),
    .data_en     (data_en),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .any_held    (any_held),
    .last_code   (last_code),
    .last_valid  (last_valid),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]    data;
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic          valid;
    logic [8:0]    code;
    logic          err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending prefix bytes kept as a list, Pause skip count.
  logic [NK-1:0] m_held;
  logic [8:0]    m_code;
  logic [7:0]    m_pend[$];
  int            m_skip;

  function automatic vec_t mk(input logic [7:0] d, input logic [NK-1:0] h,
                              input logic [NK-1:0] p, input logic [NK-1:0] r,
                              input logic v, input logic [8:0] c, input logic e);
    vec_t t;
    t.data = d; t.held = h; t.press = p; t.rel = r;
    t.valid = v; t.code = c; t.err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [NK-1:0] h, input logic [NK-1:0] p,
                           input logic [NK-1:0] r, input logic v, input logic [8:0] c,
                           input logic e);
    check({tag, ".held"},    32'(key_held),    32'(h));
    check({tag, ".press"},   32'(key_press),   32'(p));
    check({tag, ".release"}, 32'(key_release), 32'(r));
    check({tag, ".any"},     32'(any_held),    32'(|h));
    check({tag, ".valid"},   32'(last_valid),  32'(v));
    check({tag, ".code"},    32'(last_code),   32'(c));
    check({tag, ".err"},     32'(proto_err),   32'(e));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    data_en = 1'b1;
    @(posedge clk);
    #1;
    data_en = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  function automatic logic pend_has(input logic [7:0] b);
    foreach (m_pend[k]) if (m_pend[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [7:0] b, output logic [NK-1:0] p,
                            output logic [NK-1:0] r, output logic v, output logic e);
    logic [8:0] code;
    logic       brk;
    logic       done;
    p = '0; r = '0; v = 1'b0; e = 1'b0; done = 1'b0; brk = 1'b0;
    code = {pend_has(8'hE0), b};
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'h00 || b == 8'hFF || b == 8'hAA) begin
      m_held = '0; e = 1'b1; m_pend.delete();
    end else if (pend_has(8'hF0)) begin
      if (b == 8'hE0) begin
        e = 1'b1; m_pend.delete();
      end else begin
        done = 1'b1; brk = 1'b1;
      end
    end else if (b == 8'hF0) begin
      m_pend.push_back(b);
    end else if (b == 8'hE0) begin
      if (m_pend.size() == 0) m_pend.push_back(b);
    end else if (b == 8'hE1 && m_pend.size() == 0) begin
      m_skip = 7;
    end else begin
      done = 1'b1;
    end
    if (done) begin
      for (int i = 0; i < NK; i++) begin
        if (TB_CODES[i] == code) begin
          if (brk && m_held[i]) begin r[i] = 1'b1; m_held[i] = 1'b0; end
          if (!brk && !m_held[i]) begin p[i] = 1'b1; m_held[i] = 1'b1; end
        end
      end
      m_code = code; v = 1'b1; m_pend.delete();
    end
  endtask

  initial begin
    logic [NK-1:0] ep, er;
    logic          ev, ee;
    logic [7:0]    b;
    int            r;

    // Directed sequence: make/break, typematic, extended, Pause skip, errors.
    vecs.push_back(mk(8'h1D, 11'h001, 11'h001, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h001, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h000, 11'h000, 11'h001, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h001, 11'h001, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h001, 11'h000, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h001, 11'h000, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h001, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h000, 11'h000, 11'h001, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h000, 11'h000, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hE0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b0));
    vecs.push_back(mk(8'h75, 11'h010, 11'h010, 11'h000, 1'b1, 9'h175, 1'b0));
    vecs.push_back(mk(8'h75, 11'h010, 11'h000, 11'h000, 1'b1, 9'h075, 1'b0));
    vecs.push_back(mk(8'hE0, 11'h010, 11'h000, 11'h000, 1'b0, 9'h075, 1'b0));
    vecs.push_back(mk(8'hE0, 11'h010, 11'h000, 11'h000, 1'b0, 9'h075, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h010, 11'h000, 11'h000, 1'b0, 9'h075, 1'b0));
    vecs.push_back(mk(8'h75, 11'h000, 11'h000, 11'h010, 1'b1, 9'h175, 1'b0));
    vecs.push_back(mk(8'hE1, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'h14, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'h77, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'hE1, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'h14, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'h77, 11'h000, 11'h000, 11'h000, 1'b0, 9'h175, 1'b0));
    vecs.push_back(mk(8'h1C, 11'h002, 11'h002, 11'h000, 1'b1, 9'h01C, 1'b0));
    vecs.push_back(mk(8'hF0, 11'h002, 11'h000, 11'h000, 1'b0, 9'h01C, 1'b0));
    vecs.push_back(mk(8'h1C, 11'h000, 11'h000, 11'h002, 1'b1, 9'h01C, 1'b0));
    vecs.push_back(mk(8'h1D, 11'h001, 11'h001, 11'h000, 1'b1, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hFF, 11'h000, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b1));
    vecs.push_back(mk(8'hF0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b0));
    vecs.push_back(mk(8'hE0, 11'h000, 11'h000, 11'h000, 1'b0, 9'h01D, 1'b1));
    vecs.push_back(mk(8'h29, 11'h100, 11'h100, 11'h000, 1'b1, 9'h029, 1'b0));
    vecs.push_back(mk(8'hE0, 11'h100, 11'h000, 11'h000, 1'b0, 9'h029, 1'b0));
    vecs.push_back(mk(8'hAA, 11'h000, 11'h000, 11'h000, 1'b0, 9'h029, 1'b1));
    vecs.push_back(mk(8'h74, 11'h000, 11'h000, 11'h000, 1'b1, 9'h074, 1'b0));

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, '0, '0, 1'b0, 9'h000, 1'b0);
    resetn = 1'b1;

    foreach (vecs[n]) begin
      send(vecs[n].data);
      check_all($sformatf("vec%0d", n), vecs[n].held, vecs[n].press, vecs[n].rel,
                vecs[n].valid, vecs[n].code, vecs[n].err);
    end

    // Random byte stream against the model; gaps stay far below the timeout.
    do_reset();
    m_held = '0; m_code = 9'h000; m_pend.delete(); m_skip = 0;
    for (int n = 0; n < 500; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        idle_cycle();
        check_all($sformatf("rnd%0d.gap", n), m_held, '0, '0, 1'b0, m_code, 1'b0);
      end
      r = int'($urandom_range(0, 99));
      if (r < 45)      b = TB_CODES[$urandom_range(0, NK-1)][7:0];
      else if (r < 60) b = 8'hF0;
      else if (r < 72) b = 8'hE0;
      else if (r < 74) b = 8'hE1;
      else if (r < 76) b = (r == 74) ? 8'hFF : 8'hAA;
      else             b = 8'($urandom_range(0, 255));
      model_step(b, ep, er, ev, ee);
      send(b);
      check_all($sformatf("rnd%0d.b%02h", n, b), m_held, ep, er, ev, m_code, ee);
    end

    // Stalled E0 prefix: exactly TMO cycles later a single error pulse.
    do_reset();
    send(8'h76);
    check_all("tmo.esc", 11'h400, 11'h400, '0, 1'b1, 9'h076, 1'b0);
    send(8'hE0);
    for (int k = 1; k < TMO; k++) begin
      idle_cycle();
      check($sformatf("tmo.wait%0d.err", k), 32'(proto_err), 32'd0);
    end
    idle_cycle();
    check_all("tmo.fire", 11'h400, '0, '0, 1'b0, 9'h076, 1'b1);
    idle_cycle();
    check("tmo.after.err", 32'(proto_err), 32'd0);
    send(8'h1D);
    check_all("tmo.next", 11'h401, 11'h001, '0, 1'b1, 9'h01D, 1'b0);

    // Reset in the middle of a break sequence.
    do_reset();
    send(8'h1D);
    send(8'hF0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst.during", '0, '0, '0, 1'b0, 9'h000, 1'b0);
    resetn = 1'b1;
    send(8'h29);
    check_all("rst.space", 11'h100, 11'h100, '0, 1'b1, 9'h029, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
